// File: rtl/key_event_decoder.sv
// key_event_decoder: PS/2 frame receiver with E0/F0 prefix tracking and game-key mapping
module key_event_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [12:0] key_down,
    output logic [8:0]  last_change,
    output logic        been_ready,
    output logic        frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] F_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} pfx_t;
    pfx_t state, nstate;
    logic [1:0] ck_sy, dt_sy;
    logic fclk, fall, par, byte_ok, byte_vld, byte_bad, ext, brk, hit, evt;
    logic [FW-1:0] fcnt;
    logic [TW-1:0] tcnt;
    logic [3:0] bcnt;
    logic [7:0] sr;
    logic [8:0] code;
    assign fall     = fclk & ~ck_sy[1] & (fcnt == F_MAX);
    assign byte_ok  = (^{sr, par}) & dt_sy[1];
    assign byte_vld = fall & (bcnt == 4'd10) & byte_ok;
    assign byte_bad = fall & (bcnt == 4'd10) & ~byte_ok;
    // Pins idle high, so sync and filter start high to avoid a phantom edge after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck_sy <= 2'b11;
            dt_sy <= 2'b11;
            fclk  <= 1'b1;
            fcnt  <= '0;
        end else begin
            ck_sy <= {ck_sy[0], ps2_clk};
            dt_sy <= {dt_sy[0], ps2_data};
            if (ck_sy[1] == fclk) fcnt <= '0;
            else if (fcnt == F_MAX) begin
                fclk <= ck_sy[1];
                fcnt <= '0;
            end else fcnt <= fcnt + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt      <= '0;
            tcnt      <= '0;
            sr        <= '0;
            par       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                if (bcnt == 4'd0) begin
                    if (dt_sy[1]) frame_err <= 1'b1;
                    else bcnt <= 4'd1;
                end else if (bcnt < 4'd9) begin
                    sr   <= {dt_sy[1], sr[7:1]};
                    bcnt <= bcnt + 1'b1;
                end else if (bcnt == 4'd9) begin
                    par  <= dt_sy[1];
                    bcnt <= 4'd10;
                end else begin
                    bcnt      <= '0;
                    frame_err <= ~byte_ok;
                end
            end else if (bcnt != 4'd0) begin
                if (tcnt == T_MAX) begin
                    frame_err <= 1'b1;
                    bcnt      <= '0;
                    tcnt      <= '0;
                end else tcnt <= tcnt + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nstate;
    end
    always_comb begin
        nstate = state;
        evt    = 1'b0;
        code   = '0;
        hit    = 1'b1;
        ext    = (state == EXT) || (state == EXTBRK);
        brk    = (state == BRK) || (state == EXTBRK);
        case ({ext, sr})
            9'h16B:  code = 9'd5;
            9'h174:  code = 9'd6;
            9'h175:  code = 9'd4;
            9'h172:  code = 9'd12;
            9'h029:  code = 9'd3;
            9'h15A:  code = 9'd11;
            default: hit = 1'b0;
        endcase
        if (byte_vld) begin
            if (!brk && sr == 8'hE0) nstate = EXT;
            else if (!brk && sr == 8'hF0) nstate = ext ? EXTBRK : BRK;
            else begin
                nstate = IDLE;
                evt    = hit;
            end
        end else if (byte_bad) nstate = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_down    <= '0;
            last_change <= '0;
            been_ready  <= 1'b0;
        end else begin
            been_ready <= evt;
            if (evt) begin
                key_down[code[3:0]] <= ~brk;
                last_change         <= code;
            end
        end
    end
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed PS/2 frames with an expected-event queue checked on each output pulse
module tb_key_event_decoder;
    localparam int TO = 400;
    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [12:0] key_down;
    logic [8:0]  last_change;
    logic        been_ready, frame_err;
    int checks = 0, failures = 0;
    typedef struct packed {logic err; logic [12:0] kd; logic [8:0] lc;} exp_t;
    exp_t q[$];

    key_event_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_down(key_down), .last_change(last_change),
        .been_ready(been_ready), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (10) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (20) @(posedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bits({1'b1, bad_par ? ^b : ~^b, b, 1'b0}, 11);
    endtask

    task automatic expect_evt(input logic err, input logic [12:0] kd, input logic [8:0] lc);
        q.push_back('{err, kd, lc});
    endtask

    always @(negedge clk) begin
        if (!rst && (been_ready || frame_err)) begin
            exp_t e;
            chk("exclusive", 32'(been_ready & frame_err), 32'd0);
            if (q.size() == 0) chk("unexpected_pulse", 32'({been_ready, frame_err}), 32'd0);
            else begin
                e = q.pop_front();
                chk("pulse_kind", 32'(frame_err), 32'(e.err));
                chk("key_down", 32'(key_down), 32'(e.kd));
                if (!e.err) chk("last_change", 32'(last_change), 32'(e.lc));
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_key_down", 32'(key_down), 32'd0);
        chk("rst_last_change", 32'(last_change), 32'd0);
        chk("rst_been_ready", 32'(been_ready), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        repeat (20) @(posedge clk);
        // up make, then up break
        send_byte(8'hE0, 1'b0);
        expect_evt(1'b0, 13'h0010, 9'd4);
        send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        expect_evt(1'b0, 13'h0000, 9'd4);
        send_byte(8'h75, 1'b0);
        // left + space held, then left released
        send_byte(8'hE0, 1'b0);
        expect_evt(1'b0, 13'h0020, 9'd5);
        send_byte(8'h6B, 1'b0);
        expect_evt(1'b0, 13'h0028, 9'd3);
        send_byte(8'h29, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        expect_evt(1'b0, 13'h0008, 9'd5);
        send_byte(8'h6B, 1'b0);
        // parity error leaves key_down alone
        expect_evt(1'b1, 13'h0008, 9'd0);
        send_byte(8'h1C, 1'b1);
        // unmapped make: no pulse
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        expect_evt(1'b0, 13'h0000, 9'd3);
        send_byte(8'h29, 1'b0);
        // truncated frame times out, then a clean frame decodes
        expect_evt(1'b1, 13'h0000, 9'd0);
        send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
        repeat (TO + 100) @(posedge clk);
        expect_evt(1'b0, 13'h0008, 9'd3);
        send_byte(8'h29, 1'b0);
        // down make plus three typematic repeats
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hE0, 1'b0);
            expect_evt(1'b0, 13'h1008, 9'd12);
            send_byte(8'h72, 1'b0);
        end
        repeat (30) @(posedge clk);
        chk("drain_before_reset", 32'(q.size()), 32'd0);
        send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_key_down", 32'(key_down), 32'd0);
        chk("midrst_last_change", 32'(last_change), 32'd0);
        chk("midrst_been_ready", 32'(been_ready), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        expect_evt(1'b0, 13'h0008, 9'd3);
        send_byte(8'h29, 1'b0);
        repeat (30) @(posedge clk);
        chk("drain_final", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
